// File: rtl/btb_pkg.sv
// ============================================================================
// Module : btb_pkg
// Brief  : Shared types, counter encodings and helpers for the associative BTB
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Default geometry: 32-bit PC, 16 sets -> 26-bit tag.
  localparam int BTB_ADDR_W = 32;
  localparam int BTB_TAG_W  = 26;

  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
    ctr_t                  ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) begin
      case (c)
        CTR_SNT: r = CTR_WNT;
        CTR_WNT: r = CTR_WT;
        default: r = CTR_ST;
      endcase
    end else begin
      case (c)
        CTR_ST:  r = CTR_WT;
        CTR_WT:  r = CTR_WNT;
        default: r = CTR_SNT;
      endcase
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_plru.sv
// ============================================================================
// Module : btb_plru
// Brief  : Combinational tree pseudo-LRU for one set (next state + victim)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btb_plru #(
  parameter  int WAYS    = 2,
  localparam int STATE_W = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [WAY_W-1:0]   touch_i,
  output logic [STATE_W-1:0] state_o,
  output logic [WAY_W-1:0]   victim_o
);

  generate
    if (WAYS == 1) begin : g_single
      logic unused_touch;
      assign unused_touch = ^touch_i;
      assign state_o      = state_i;
      assign victim_o     = '0;
    end else begin : g_tree
      localparam int LVLS = $clog2(WAYS);

      // Node bit points at the LRU half: 0 = left subtree, 1 = right subtree.
      always_comb begin
        int node_t;
        state_o = state_i;
        node_t  = 0;
        for (int l = 0; l < LVLS; l++) begin
          state_o[node_t] = ~touch_i[LVLS-1-l];
          node_t = 2 * node_t + 1 + int'(touch_i[LVLS-1-l]);
        end
      end

      always_comb begin
        int   node_v;
        logic b;
        victim_o = '0;
        node_v   = 0;
        for (int l = 0; l < LVLS; l++) begin
          b = state_i[node_v];
          victim_o[LVLS-1-l] = b;
          node_v = 2 * node_v + 1 + int'(b);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/btb_assoc.sv
// ============================================================================
// Module : btb_assoc
// Brief  : Set-associative BTB with 2-bit counters, tree PLRU and flush.
//          Optional same-edge update bypass: define BTB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btb_assoc
  import btb_pkg::*;
#(
  parameter int   ADDR_WIDTH = 32,
  parameter int   BTB_SETS   = 16,
  parameter int   BTB_WAYS   = 2,
  parameter ctr_t CTR_INIT   = CTR_WT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] predict_pc,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  output logic [ADDR_WIDTH-1:0] predicted_pc,
  output logic                  prediction,
  output logic                  hit
);

  localparam int IDX_W  = $clog2(BTB_SETS);
  localparam int TAG_W  = ADDR_WIDTH - 2 - IDX_W;
  localparam int WAY_W  = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
  localparam int PLRU_W = (BTB_WAYS > 1) ? BTB_WAYS - 1 : 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [ADDR_WIDTH-1:0] target;
    ctr_t                  ctr;
  } entry_t;

  entry_t              ent_q  [BTB_SETS][BTB_WAYS];
  logic [PLRU_W-1:0]   plru_q [BTB_SETS];
  logic [PLRU_W-1:0]   plru_d [BTB_SETS];
  logic [WAY_W-1:0]    victim [BTB_SETS];

  logic                  hit_q, hit_d;
  logic                  pred_q, pred_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             unused_pc_lsbs;

  assign lk_idx  = predict_pc[2 +: IDX_W];
  assign lk_tag  = predict_pc[ADDR_WIDTH-1 -: TAG_W];
  assign upd_idx = update_pc[2 +: IDX_W];
  assign upd_tag = update_pc[ADDR_WIDTH-1 -: TAG_W];
  assign unused_pc_lsbs = ^{predict_pc[1:0], update_pc[1:0]};

  logic   lk_hit;
  entry_t lk_ent;

  always_comb begin
    lk_hit = 1'b0;
    lk_ent = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (ent_q[lk_idx][w].valid && ent_q[lk_idx][w].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_ent = ent_q[lk_idx][w];
      end
    end
  end

  logic             upd_hit, upd_free, upd_we;
  logic [WAY_W-1:0] upd_hit_way, upd_free_way, upd_way;
  entry_t           upd_old, upd_new;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    upd_hit      = 1'b0;
    upd_free     = 1'b0;
    upd_hit_way  = '0;
    upd_free_way = '0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (ent_q[upd_idx][w].valid && ent_q[upd_idx][w].tag == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!ent_q[upd_idx][w].valid) begin
        upd_free     = 1'b1;
        upd_free_way = WAY_W'(w);
      end
    end
  end

  assign upd_way = upd_hit  ? upd_hit_way  :
                   upd_free ? upd_free_way : victim[upd_idx];
  assign upd_we  = update_valid && (upd_hit || update_taken);
  assign upd_old = ent_q[upd_idx][upd_way];

  always_comb begin
    upd_new = upd_old;
    if (upd_hit) begin
      upd_new.ctr = ctr_update(upd_old.ctr, update_taken);
      if (update_taken) upd_new.target = update_target;
    end else begin
      upd_new.valid  = 1'b1;
      upd_new.tag    = upd_tag;
      upd_new.target = update_target;
      upd_new.ctr    = CTR_INIT;
    end
  end

  for (genvar s = 0; s < BTB_SETS; s++) begin : g_plru
    btb_plru #(.WAYS(BTB_WAYS)) u_plru (
      .state_i  (plru_q[s]),
      .touch_i  (upd_way),
      .state_o  (plru_d[s]),
      .victim_o (victim[s])
    );
  end

  logic byp;
`ifdef BTB_BYPASS_EN
  assign byp = upd_we && (upd_idx == lk_idx) && (upd_tag == lk_tag);
`else
  assign byp = 1'b0;
`endif

  entry_t sel_ent;
  logic   sel_hit;

  always_comb begin
    sel_ent = byp ? upd_new : lk_ent;
    sel_hit = byp | lk_hit;
    hit_d   = sel_hit;
    pred_d  = sel_hit & sel_ent.ctr[1];
    tgt_d   = sel_hit ? sel_ent.target : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < BTB_WAYS; w++) ent_q[s][w].valid <= 1'b0;
      end
      hit_q  <= 1'b0;
      pred_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      hit_q  <= hit_d;
      pred_q <= pred_d;
      tgt_q  <= tgt_d;
      if (upd_we) begin
        ent_q[upd_idx][upd_way] <= upd_new;
        plru_q[upd_idx]         <= plru_d[upd_idx];
      end
    end
  end

  assign hit          = hit_q;
  assign prediction   = pred_q;
  assign predicted_pc = tgt_q;

endmodule

`default_nettype wire
